direct_sound_fifo: RTL and testbench

//  Producer-side sample FIFO for one Direct Sound channel (instantiated twice: FIFO A, FIFO B).

---
 rtl/direct_sound_fifo.sv | 127 ++++++++++++
 tb/tb_direct_sound_fifo.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/direct_sound_fifo.sv
// Producer-side sample FIFO for one Direct Sound channel: assembles MMIO/DMA
// halfword or word writes into 32-bit samples and presents a show-ahead head word.
module direct_sound_fifo #(
    parameter int DEPTH  = 8,
    parameter int SIZE_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        wr_be,
    input  logic [31:0]       wr_data,
    input  logic              FIFO_re,
    input  logic              FIFO_clr,
    output logic [31:0]       FIFO_val,
    output logic [SIZE_W-1:0] FIFO_size,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SIZE_W-1:0] FULL_CNT = SIZE_W'(DEPTH);

    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
    logic [SIZE_W-1:0] count, count_n;
    logic [15:0]       staging, staging_n;
    logic              stage_vld, stage_vld_n;
    logic              push_req, push_ok, pop_ok;
    logic [31:0]       push_word, val_n;
    logic              ovf_n, unf_n;

    always_comb begin
        push_req    = 1'b0;
        push_word   = wr_data;
        staging_n   = staging;
        stage_vld_n = stage_vld;

        if (wr_en) begin
            unique case (wr_be)
                2'b11: push_req = 1'b1;
                2'b01: begin
                    staging_n   = wr_data[15:0];
                    stage_vld_n = 1'b1;
                end
                2'b10: begin
                    push_req    = 1'b1;
                    push_word   = {wr_data[31:16], stage_vld ? staging : 16'h0};
                    stage_vld_n = 1'b0;
                end
                default: ;
            endcase
        end

        pop_ok  = FIFO_re && (count != '0);
        push_ok = push_req && ((count != FULL_CNT) || pop_ok);
        ovf_n   = push_req && !push_ok;
        unf_n   = FIFO_re && (count == '0);

        rd_ptr_n = pop_ok  ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_ptr_n = push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;

        unique case ({push_ok, pop_ok})
            2'b10:   count_n = count + SIZE_W'(1);
            2'b01:   count_n = count - SIZE_W'(1);
            default: count_n = count;
        endcase

        // The head word may be the one being written this cycle; bypass the array.
        if (count_n == '0)
            val_n = '0;
        else if (push_ok && (wr_ptr == rd_ptr_n))
            val_n = push_word;
        else
            val_n = mem[rd_ptr_n];

        if (FIFO_clr) begin
            push_ok     = 1'b0;
            ovf_n       = 1'b0;
            unf_n       = 1'b0;
            rd_ptr_n    = '0;
            wr_ptr_n    = '0;
            count_n     = '0;
            staging_n   = '0;
            stage_vld_n = 1'b0;
            val_n       = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            staging   <= '0;
            stage_vld <= 1'b0;
            FIFO_val  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr_n;
            count     <= count_n;
            staging   <= staging_n;
            stage_vld <= stage_vld_n;
            FIFO_val  <= val_n;
            overflow  <= ovf_n;
            underflow <= unf_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_ok)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            assert (count <= FULL_CNT);
    end

    assign FIFO_size  = count;
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

endmodule

// File: tb/tb_direct_sound_fifo.sv
// Directed, table-driven bench for direct_sound_fifo (DEPTH=8) with hand
// sequences for clear, full-clear and mid-stream reset.
module tb_direct_sound_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_be = 2'b00;
    logic [31:0] wr_data = '0;
    logic        FIFO_re = 1'b0;
    logic        FIFO_clr = 1'b0;
    logic [31:0] FIFO_val;
    logic [3:0]  FIFO_size;
    logic        fifo_full, fifo_empty, overflow, underflow;

    always #5 clock = ~clock;

    direct_sound_fifo #(.DEPTH(8), .SIZE_W(4)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data),
        .FIFO_re(FIFO_re), .FIFO_clr(FIFO_clr), .FIFO_val(FIFO_val), .FIFO_size(FIFO_size),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  be;
        logic [31:0] data;
        logic        re;
        logic        clr;
        logic [3:0]  size;
        logic [31:0] val;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    function automatic vec_t mk(logic rst, logic we, logic [1:0] be, logic [31:0] data,
                                logic re, logic clr, logic [3:0] size, logic [31:0] val,
                                logic ovf, logic unf);
        vec_t v;
        v.rst = rst; v.we = we; v.be = be; v.data = data; v.re = re; v.clr = clr;
        v.size = size; v.val = val; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] size, input logic [31:0] val,
                             input logic ovf, input logic unf);
        chk({tag, ".size"},  32'(FIFO_size), 32'(size));
        chk({tag, ".val"},   FIFO_val, val);
        chk({tag, ".ovf"},   32'(overflow), 32'(ovf));
        chk({tag, ".unf"},   32'(underflow), 32'(unf));
        chk({tag, ".empty"}, 32'(fifo_empty), 32'(size == 4'd0));
        chk({tag, ".full"},  32'(fifo_full), 32'(size == 4'd8));
    endtask

    task automatic drive(input logic rst, input logic we, input logic [1:0] be,
                         input logic [31:0] data, input logic re, input logic clr);
        @(negedge clock);
        reset = rst; wr_en = we; wr_be = be; wr_data = data; FIFO_re = re; FIFO_clr = clr;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset and four full-word writes, then drain
        vecs.push_back(mk(1, 0, 2'b00, 32'h0,        0, 0, 4'd0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 2'b11, 32'h11111111, 0, 0, 4'd1, 32'h11111111, 0, 0));
        vecs.push_back(mk(0, 1, 2'b11, 32'h22222222, 0, 0, 4'd2, 32'h11111111, 0, 0));
        vecs.push_back(mk(0, 1, 2'b11, 32'h33333333, 0, 0, 4'd3, 32'h11111111, 0, 0));
        vecs.push_back(mk(0, 1, 2'b11, 32'h44444444, 0, 0, 4'd4, 32'h11111111, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        1, 0, 4'd3, 32'h22222222, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        1, 0, 4'd2, 32'h33333333, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        1, 0, 4'd1, 32'h44444444, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        1, 0, 4'd0, 32'h0,        0, 0));
        // halfword assembly and lone upper halfword
        vecs.push_back(mk(0, 1, 2'b01, 32'h0000BEEF, 0, 0, 4'd0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 32'hDEAD0000, 0, 0, 4'd1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 32'hCAFE0000, 0, 0, 4'd2, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 1, 2'b00, 32'h55555555, 0, 0, 4'd2, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        1, 0, 4'd1, 32'hCAFE0000, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        1, 0, 4'd0, 32'h0,        0, 0));
        // underflow, then push+pop on empty
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        1, 0, 4'd0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 4'd0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 2'b11, 32'hAAAA0001, 1, 0, 4'd1, 32'hAAAA0001, 0, 1));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        1, 0, 4'd0, 32'h0,        0, 0));
        // fill across the pointer wrap, overflow, push+pop while full, drain
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 2'b11, 32'hA0000000 + 32'(i), 0, 0, 4'(i + 1), 32'hA0000000, 0, 0));
        vecs.push_back(mk(0, 1, 2'b11, 32'hBAD00009, 0, 0, 4'd8, 32'hA0000000, 1, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,        0, 0, 4'd8, 32'hA0000000, 0, 0));
        vecs.push_back(mk(0, 1, 2'b11, 32'hA0000008, 1, 0, 4'd8, 32'hA0000001, 0, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 0, 2'b00, 32'h0, 1, 0, 4'(8 - i),
                              (i == 8) ? 32'h0 : 32'hA0000001 + 32'(i), 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].be, vecs[i].data, vecs[i].re, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].size, vecs[i].val, vecs[i].ovf, vecs[i].unf);
        end

        // clear with simultaneous write/read discards staging and the push
        for (int i = 0; i < 5; i++)
            drive(0, 1, 2'b11, 32'h50000000 + 32'(i), 0, 0);
        check_all("clr.pre", 4'd5, 32'h50000000, 0, 0);
        drive(0, 1, 2'b01, 32'h0000FFFF, 0, 0);
        drive(0, 1, 2'b11, 32'h99999999, 1, 1);
        check_all("clr.hit", 4'd0, 32'h0, 0, 0);
        drive(0, 1, 2'b10, 32'h12340000, 0, 0);
        check_all("clr.stage", 4'd1, 32'h12340000, 0, 0);

        // clear while full with a write: no overflow; clear on empty with read: no underflow
        for (int i = 0; i < 7; i++)
            drive(0, 1, 2'b11, 32'h60000000 + 32'(i), 0, 0);
        check_all("clrfull.pre", 4'd8, 32'h12340000, 0, 0);
        drive(0, 1, 2'b11, 32'h66666666, 0, 1);
        check_all("clrfull.hit", 4'd0, 32'h0, 0, 0);
        drive(0, 0, 2'b00, 32'h0, 1, 1);
        check_all("clrempty.re", 4'd0, 32'h0, 0, 0);

        // reset mid-stream with pending staged half and active inputs
        for (int i = 0; i < 3; i++)
            drive(0, 1, 2'b11, 32'h70000000 + 32'(i), 0, 0);
        drive(0, 1, 2'b01, 32'h00007777, 0, 0);
        check_all("rst.pre", 4'd3, 32'h70000000, 0, 0);
        drive(1, 1, 2'b11, 32'h88888888, 1, 0);
        check_all("rst.hit", 4'd0, 32'h0, 0, 0);
        drive(0, 1, 2'b10, 32'hABCD0000, 0, 0);
        check_all("rst.stage", 4'd1, 32'hABCD0000, 0, 0);
        drive(0, 0, 2'b00, 32'h0, 1, 0);
        check_all("rst.pop", 4'd0, 32'h0, 0, 0);

        drive(0, 0, 2'b00, 32'h0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
